compressor: RTL and testbench

- Streaming word-elimination compressor for 256-bit (8 x 32-bit word) AXI-Stream-style beats.
- Each accepted input beat yields exactly one registered output beat, either compressed (header plus surviving words) or raw. Valid bytes are marked by `tkeep`.
- Sits between a wide data source and a packer or DMA that consumes `tkeep`-qualified beats. The matching decompressor relies on the header format below.

---
 rtl/compressor_pkg.sv | 19 +
 rtl/compressor_pack.sv | 64 ++++++
 rtl/compressor.sv | 63 ++++++
 tb/tb_compressor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// Shared constants for the word-elimination compressor.
// Optional build macro: COMPRESSOR_ZERO_WORD_EN (zero words also compressible).
package compressor_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_DATA     = 8;
  localparam int MIN_HITS     = 2;
  localparam int BUS_W        = DATA_WIDTH * NUM_DATA;
  localparam int BPW          = DATA_WIDTH / 8;          // bytes per word
  localparam int KEEP_W       = BUS_W / 8;
  localparam int CNT_W        = $clog2(NUM_DATA + 1);
  localparam int SH_W         = $clog2(KEEP_W) + 1;

  // Header field offsets inside word 0
  localparam int HDR_MASK_LSB = 0;
  localparam int HDR_ZERO_LSB = 8;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [KEEP_W-1:0]     RAW_KEEP = '1;
endpackage

// File: rtl/compressor_pack.sv
// Combinational mask-driven word compactor: header + surviving words, tkeep.
// With COMPRESSOR_ZERO_WORD_EN, all-zero words are also eliminated and
// flagged in the header zero-kind field.
module compressor_pack
  import compressor_pkg::*;
(
  input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] i_words,
  output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] o_words,
  output logic [KEEP_W-1:0]                   o_keep,
  output logic                                o_compress
);
  logic [NUM_DATA-1:0]            w_ones;
  logic [NUM_DATA-1:0]            w_zero;
  logic [NUM_DATA-1:0]            w_mask;
  logic [NUM_DATA-1:0][CNT_W-1:0] w_pos;
  logic [CNT_W-1:0]               w_k;
  logic [SH_W-1:0]                w_sh;
  logic [DATA_WIDTH-1:0]          w_hdr;

  // Per-word compressibility classification
  for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_cls
    assign w_ones[gi] = (i_words[gi] == ALL_ONES);
`ifdef COMPRESSOR_ZERO_WORD_EN
    assign w_zero[gi] = (i_words[gi] == '0);
`else
    assign w_zero[gi] = 1'b0;
`endif
    assign w_mask[gi] = w_ones[gi] | w_zero[gi];
  end

  // Prefix count of kept words: w_pos[i] = kept words below index i
  always_comb begin
    w_pos = '0;
    w_k   = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      w_pos[i] = w_k;
      w_k      = w_k + {{(CNT_W-1){1'b0}}, ~w_mask[i]};
    end
  end

  // Header word: mask in the low byte, zero-kind flags above it
  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_MASK_LSB +: NUM_DATA] = w_mask;
    w_hdr[HDR_ZERO_LSB +: NUM_DATA] = w_zero;
  end

  // Each destination slot j>=1 picks the kept source word whose prefix is j-1
  always_comb begin
    o_words    = '0;
    o_words[0] = w_hdr;
    for (int j = 1; j < NUM_DATA; j++) begin
      for (int i = 0; i < NUM_DATA; i++) begin
        if (!w_mask[i] && (w_pos[i] == CNT_W'(j - 1)))
          o_words[j] = i_words[i];
      end
    end
  end

  // Header plus k words are valid; k <= NUM_DATA-MIN_HITS whenever used
  assign w_sh       = SH_W'((32'(w_k) + 32'd1) * BPW);
  assign o_keep     = ~(RAW_KEEP << w_sh);
  assign o_compress = ((CNT_W'(NUM_DATA) - w_k) >= CNT_W'(MIN_HITS));
endmodule

// File: rtl/compressor.sv
// Streaming compressor top: accept/stall handshake and registered output beat.
// Optional build macro: COMPRESSOR_ZERO_WORD_EN (handled in compressor_pack).
module compressor
  import compressor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wrt_en,
  input  logic [BUS_W-1:0]  data_in,
  input  logic              tvalid_in,
  input  logic              tlast_in,
  input  logic              tready_in,
  output logic [BUS_W-1:0]  data_out,
  output logic              tvalid_out,
  output logic              tlast_out,
  output logic [KEEP_W-1:0] tkeep
);
  logic [BUS_W-1:0]  r_data;
  logic              r_valid;
  logic              r_last;
  logic [KEEP_W-1:0] r_keep;

  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] w_pack_words;
  logic [KEEP_W-1:0]                   w_pack_keep;
  logic                                w_compress;
  logic                                w_accept;
  logic [BUS_W-1:0]                    w_data;
  logic [KEEP_W-1:0]                   w_keep;

  compressor_pack u_pack (
    .i_words    (data_in),
    .o_words    (w_pack_words),
    .o_keep     (w_pack_keep),
    .o_compress (w_compress)
  );

  // No upstream ready: beats arriving during a stall are simply dropped
  assign w_accept = wrt_en & tvalid_in & (~r_valid | tready_in);
  assign w_data   = w_compress ? w_pack_words : data_in;
  assign w_keep   = w_compress ? w_pack_keep  : RAW_KEEP;

  // Output beat register; holds while stalled, clears valid once drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_keep  <= '0;
    end else if (w_accept) begin
      r_data  <= w_data;
      r_valid <= 1'b1;
      r_last  <= tlast_in;
      r_keep  <= w_keep;
    end else if (tready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign tvalid_out = r_valid;
  assign tlast_out  = r_last;
  assign tkeep      = r_keep;
endmodule

// File: tb/tb_compressor.sv
// Directed + randomised scoreboard bench for compressor.
module tb_compressor;
  logic         clk = 1'b0;
  logic         reset;
  logic         wrt_en;
  logic [255:0] data_in;
  logic         tvalid_in;
  logic         tlast_in;
  logic         tready_in;
  logic [255:0] data_out;
  logic         tvalid_out;
  logic         tlast_out;
  logic [31:0]  tkeep;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  beat_t sb[$];
  beat_t held;
  logic  exp_valid;
  int    n_vec = 0;
  int    n_err = 0;

  compressor dut (
    .clk        (clk),
    .reset      (reset),
    .wrt_en     (wrt_en),
    .data_in    (data_in),
    .tvalid_in  (tvalid_in),
    .tlast_in   (tlast_in),
    .tready_in  (tready_in),
    .data_out   (data_out),
    .tvalid_out (tvalid_out),
    .tlast_out  (tlast_out),
    .tkeep      (tkeep)
  );

  always #5 clk = ~clk;

  // Reference: walk source words, append survivors, count hits
  function automatic beat_t model(input logic [255:0] d, input logic l);
    beat_t       r;
    logic [287:0] tmp;
    logic [7:0]  m;
    logic [7:0]  z;
    logic [31:0] w;
    int          n;
    int          hits;
    tmp = '0; m = '0; z = '0; n = 0; hits = 0;
    for (int i = 0; i < 8; i++) begin
      w = d[32*i +: 32];
      if (w == 32'hFFFFFFFF) begin
        m[i] = 1'b1; hits++;
`ifdef COMPRESSOR_ZERO_WORD_EN
      end else if (w == 32'h0) begin
        m[i] = 1'b1; z[i] = 1'b1; hits++;
`endif
      end else begin
        n++;
        tmp[32*n +: 32] = w;
      end
    end
    r.last = l;
    if (hits >= 2) begin
      tmp[31:0] = {16'h0, z, m};
      r.data = tmp[255:0];
      r.keep = 32'hFFFFFFFF >> (32 - 4 * (n + 1));
    end else begin
      r.data = d;
      r.keep = 32'hFFFFFFFF;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, step, compare
  task automatic cycle(input logic v, input logic [255:0] d, input logic l,
                       input logic rdy, input logic we);
    logic acc;
    tvalid_in = v; data_in = d; tlast_in = l; tready_in = rdy; wrt_en = we;
    acc = we & v & (~exp_valid | rdy);
    if (acc) sb.push_back(model(d, l));
    @(posedge clk); #1;
    if (acc) begin
      held = sb.pop_front();
      exp_valid = 1'b1;
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    chk("tvalid_out", 256'(tvalid_out), 256'(exp_valid));
    if (exp_valid) begin
      chk("data_out", data_out, held.data);
      chk("tkeep", 256'(tkeep), 256'(held.keep));
      chk("tlast_out", 256'(tlast_out), 256'(held.last));
    end
  endtask

  function automatic logic [31:0] rnd_word();
    int s;
    s = $urandom_range(0, 5);
    if (s < 2) return 32'hFFFFFFFF;
    if (s == 2) return 32'h0;
    return $urandom();
  endfunction

  initial begin
    logic [255:0] v1, v3, v4, rd;
    v1 = 256'hffffffffffffffff06ffffffffffdc0508ff0008ffffffffffffffffffffffff;
    v3 = 256'h85ABBB22E36EBF213EDBBE8CB5E1C045EAB0B677FB69FFFFFFFFFFFFFFFFFFFF;
    v4 = 256'h22EC40842DE0B7847741B7381FCCB789A6B3C07DAF94BF1B6D9BBF63AE393B95;
    exp_valid = 1'b0;
    reset = 1'b0; wrt_en = 1'b0; data_in = '0; tvalid_in = 1'b0;
    tlast_in = 1'b0; tready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 256'h0);
    chk("rst_valid", 256'(tvalid_out), 256'h0);
    chk("rst_last", 256'(tlast_out), 256'h0);
    chk("rst_keep", 256'(tkeep), 256'h0);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Mixed beat from the datasheet example
    cycle(1'b1, v1, 1'b0, 1'b1, 1'b1);
    chk("v1_data", data_out, {160'h0, 32'h06ffffff, 32'hffffdc05, 32'h08ff0008, 32'h000000c7});
    chk("v1_keep", 256'(tkeep), 256'h0000FFFF);

    // All-ones beat
    cycle(1'b1, {256{1'b1}}, 1'b0, 1'b1, 1'b1);
    chk("ones_data", data_out, 256'h000000ff);
    chk("ones_keep", 256'(tkeep), 256'h0000000F);

    // Exactly MIN_HITS hits
    cycle(1'b1, v3, 1'b0, 1'b1, 1'b1);
    chk("v3_hdr", 256'(data_out[31:0]), 256'h00000003);
    chk("v3_w1", 256'(data_out[63:32]), 256'hFB69FFFF);
    chk("v3_w6", 256'(data_out[223:192]), 256'h85ABBB22);
    chk("v3_w7", 256'(data_out[255:224]), 256'h0);
    chk("v3_keep", 256'(tkeep), 256'h0FFFFFFF);

    // Raw beat with tlast, then idle drains
    cycle(1'b1, v4, 1'b1, 1'b1, 1'b1);
    chk("v4_data", data_out, v4);
    chk("v4_keep", 256'(tkeep), 256'hFFFFFFFF);
    chk("v4_last", 256'(tlast_out), 256'h1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Stall: hold v1, drop a beat presented meanwhile, then drain
    cycle(1'b1, v1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, v3, 1'b1, 1'b0, 1'b1);
    chk("stall_hold", data_out, {160'h0, 32'h06ffffff, 32'hffffdc05, 32'h08ff0008, 32'h000000c7});
    cycle(1'b1, v4, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("stall_drain", 256'(tvalid_out), 256'h0);

    // Async reset mid-packet
    cycle(1'b1, v3, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_data", data_out, 256'h0);
    chk("arst_valid", 256'(tvalid_out), 256'h0);
    chk("arst_keep", 256'(tkeep), 256'h0);
    sb.delete();
    exp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Global enable off
    cycle(1'b1, v1, 1'b0, 1'b1, 1'b0);
    chk("wrt_en_off", 256'(tvalid_out), 256'h0);

    // Randomised traffic with random backpressure
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 8; i++) rd[32*i +: 32] = rnd_word();
      cycle(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
    end

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
